// File: rtl/l1_fill_ctrl_pkg.sv
// rtl/l1_fill_ctrl_pkg.sv - shared widths, response codes and entry layout for the L1 fill controller
package l1_fill_ctrl_pkg;

    localparam int ENTRIES            = 4;
    localparam int STRAND_WIDTH       = 2;
    localparam int ADDR_W             = 26;
    localparam int WAY_W              = 2;
    localparam int L1_SET_INDEX_WIDTH = 7;
    localparam int L1_TAG_WIDTH       = ADDR_W - L1_SET_INDEX_WIDTH;

    // L2 response kinds carried on l2_rsp_type
    typedef enum logic {
        L1_RSP_FILL       = 1'b0,
        L1_RSP_INVALIDATE = 1'b1
    } l1_rsp_e;

    // One outstanding miss; wait_mask holds the strands parked on this line
    typedef struct packed {
        logic                    valid;
        logic                    issued;
        logic [ADDR_W-1:0]       addr;
        logic [WAY_W-1:0]        way;
        logic [ENTRIES-1:0]      wait_mask;
    } miss_entry_t;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_BUSY = 1'b1
    } req_state_e;

    function automatic logic [ENTRIES-1:0] strand_onehot(input logic [STRAND_WIDTH-1:0] s);
        return ENTRIES'(1) << s;
    endfunction

endpackage

// File: rtl/l1_fill_ctrl_if.sv
// rtl/l1_fill_ctrl_if.sv - L2 line request / response bus between the L1 fill controller and L2
interface l1_fill_ctrl_if;

    logic                                   l2_req_valid;
    logic [l1_fill_ctrl_pkg::ADDR_W-1:0]    l2_req_addr;
    logic [l1_fill_ctrl_pkg::WAY_W-1:0]     l2_req_way;
    logic                                   l2_req_ack;
    logic                                   l2_rsp_valid;
    logic                                   l2_rsp_type;
    logic [l1_fill_ctrl_pkg::ADDR_W-1:0]    l2_rsp_addr;
    logic [l1_fill_ctrl_pkg::WAY_W-1:0]     l2_rsp_way;

    // L1 side: issues requests, consumes responses
    modport master (
        output l2_req_valid, l2_req_addr, l2_req_way,
        input  l2_req_ack,
        input  l2_rsp_valid, l2_rsp_type, l2_rsp_addr, l2_rsp_way
    );

    // L2 side: accepts requests, produces responses
    modport slave (
        input  l2_req_valid, l2_req_addr, l2_req_way,
        output l2_req_ack,
        output l2_rsp_valid, l2_rsp_type, l2_rsp_addr, l2_rsp_way
    );

endinterface

// File: rtl/l1_fill_ctrl_fill_request_arbiter.sv
// rtl/l1_fill_ctrl_fill_request_arbiter.sv - round-robin pick among entries waiting to be sent to L2
module l1_fill_ctrl_fill_request_arbiter
    import l1_fill_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ENTRIES-1:0]      req_i,
    input  logic                    ack_i,
    input  logic [STRAND_WIDTH-1:0] ack_idx_i,
    output logic                    gnt_valid_o,
    output logic [ENTRIES-1:0]      gnt_onehot_o,
    output logic [STRAND_WIDTH-1:0] gnt_idx_o
);

    logic [STRAND_WIDTH-1:0] ptr_q;
    logic [STRAND_WIDTH-1:0] ptr_d;
    logic [STRAND_WIDTH-1:0] idx;

    // Scan from the pointer upward; descending loop so the closest requester wins
    always_comb begin
        gnt_valid_o  = 1'b0;
        gnt_onehot_o = '0;
        gnt_idx_o    = '0;
        idx          = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            idx = ptr_q + STRAND_WIDTH'(i);
            if (req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = idx;
            end
        end
        if (gnt_valid_o) begin
            gnt_onehot_o[gnt_idx_o] = 1'b1;
        end
        ptr_d = ack_i ? ack_idx_i + 1'b1 : ptr_q;
    end

    // Pointer moves past the acknowledged entry only when L2 takes it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/l1_fill_ctrl.sv
// rtl/l1_fill_ctrl.sv - pending-miss tracking, L2 line requests and tag-array write generation
module l1_fill_ctrl
    import l1_fill_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          miss_i,
    input  logic [ADDR_W-1:0]             miss_addr_i,
    input  logic [STRAND_WIDTH-1:0]       miss_strand_i,
    output logic                          full_o,
    l1_fill_ctrl_if.master                l2_if,
    output logic                          update_o,
    output logic                          invalidate_o,
    output logic [WAY_W-1:0]              update_way_o,
    output logic [L1_TAG_WIDTH-1:0]       update_tag_o,
    output logic [L1_SET_INDEX_WIDTH-1:0] update_set_o,
    output logic [ENTRIES-1:0]            wake_o
);

    miss_entry_t [ENTRIES-1:0]     ent_q, ent_d;
    logic [WAY_W-1:0]              rr_q, rr_d;
    logic                          full_q, full_d;

    req_state_e                    req_state_q;
    logic                          req_valid_q;
    logic [ADDR_W-1:0]             req_addr_q;
    logic [WAY_W-1:0]              req_way_q;
    logic [STRAND_WIDTH-1:0]       req_idx_q;

    logic                          update_q, invalidate_q;
    logic [WAY_W-1:0]              upd_way_q;
    logic [L1_TAG_WIDTH-1:0]       upd_tag_q;
    logic [L1_SET_INDEX_WIDTH-1:0] upd_set_q;
    logic [ENTRIES-1:0]            wake_q, wake_d;

    logic [ENTRIES-1:0]            valid_vec, pending_vec, valid_d_vec, miss_onehot;
    logic                          rsp_fill, rsp_inval;
    logic                          fill_hit, miss_hit, miss_merge, full_now, alloc, issue_ack;
    logic [STRAND_WIDTH-1:0]       fill_idx, miss_idx, free_idx;
    logic                          gnt_valid;
    logic [ENTRIES-1:0]            gnt_onehot;
    logic [STRAND_WIDTH-1:0]       gnt_idx;
    logic [ADDR_W-1:0]             pick_addr;
    logic [WAY_W-1:0]              pick_way;

    assign rsp_fill    = l2_if.l2_rsp_valid && (l2_if.l2_rsp_type == L1_RSP_FILL);
    assign rsp_inval   = l2_if.l2_rsp_valid && (l2_if.l2_rsp_type == L1_RSP_INVALIDATE);
    assign miss_onehot = strand_onehot(miss_strand_i);
    assign full_now    = &valid_vec;
    assign miss_merge  = miss_hit && fill_hit && (miss_idx == fill_idx);
    assign alloc       = miss_i && !miss_hit && !full_now;
    assign issue_ack   = (req_state_q == REQ_BUSY) && l2_if.l2_req_ack;

    // Address match against live entries and lowest-index free slot search
    always_comb begin
        valid_vec   = '0;
        pending_vec = '0;
        fill_hit    = 1'b0;
        fill_idx    = '0;
        miss_hit    = 1'b0;
        miss_idx    = '0;
        free_idx    = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            valid_vec[i]   = ent_q[i].valid;
            pending_vec[i] = ent_q[i].valid && !ent_q[i].issued;
            if (rsp_fill && ent_q[i].valid && ent_q[i].issued &&
                ent_q[i].addr == l2_if.l2_rsp_addr) begin
                fill_hit = 1'b1;
                fill_idx = STRAND_WIDTH'(i);
            end
            if (miss_i && ent_q[i].valid && ent_q[i].addr == miss_addr_i) begin
                miss_hit = 1'b1;
                miss_idx = STRAND_WIDTH'(i);
            end
            if (!ent_q[i].valid) begin
                free_idx = STRAND_WIDTH'(i);
            end
        end
    end

    // Entry array update: issue marking, fill retirement, miss merge and allocation
    always_comb begin
        ent_d       = ent_q;
        rr_d        = rr_q;
        wake_d      = '0;
        valid_d_vec = '0;
        if (issue_ack) begin
            ent_d[req_idx_q].issued = 1'b1;
        end
        if (fill_hit) begin
            wake_d          = ent_q[fill_idx].wait_mask | (miss_merge ? miss_onehot : '0);
            ent_d[fill_idx] = '0;
        end
        if (miss_hit && !miss_merge) begin
            ent_d[miss_idx].wait_mask = ent_q[miss_idx].wait_mask | miss_onehot;
        end
        // Slot freed by a fill this cycle still reads as valid here, so it is not reused yet
        if (alloc) begin
            ent_d[free_idx].valid     = 1'b1;
            ent_d[free_idx].issued    = 1'b0;
            ent_d[free_idx].addr      = miss_addr_i;
            ent_d[free_idx].way       = rr_q;
            ent_d[free_idx].wait_mask = miss_onehot;
            rr_d                      = rr_q + 1'b1;
        end
        for (int i = 0; i < ENTRIES; i++) begin
            valid_d_vec[i] = ent_d[i].valid;
        end
        full_d = &valid_d_vec;
    end

    // Entry storage, victim counter and registered full flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q  <= '0;
            rr_q   <= '0;
            full_q <= 1'b0;
        end else begin
            ent_q  <= ent_d;
            rr_q   <= rr_d;
            full_q <= full_d;
        end
    end

    l1_fill_ctrl_fill_request_arbiter u_arb (
        .clk          (clk),
        .reset        (reset),
        .req_i        (pending_vec),
        .ack_i        (issue_ack),
        .ack_idx_i    (req_idx_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx)
    );

    // Fetch address/way of the granted entry
    always_comb begin
        pick_addr = '0;
        pick_way  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (gnt_onehot[i]) begin
                pick_addr = ent_q[i].addr;
                pick_way  = ent_q[i].way;
            end
        end
    end

    // Request FSM: present one entry, hold it until ack, then idle one cycle before the next
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_state_q <= REQ_IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_way_q   <= '0;
            req_idx_q   <= '0;
        end else begin
            case (req_state_q)
                REQ_IDLE: begin
                    if (gnt_valid) begin
                        req_state_q <= REQ_BUSY;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= pick_addr;
                        req_way_q   <= pick_way;
                        req_idx_q   <= gnt_idx;
                    end
                end
                REQ_BUSY: begin
                    if (l2_if.l2_req_ack) begin
                        req_state_q <= REQ_IDLE;
                        req_valid_q <= 1'b0;
                    end
                end
                default: begin
                    req_state_q <= REQ_IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Tag-write pulses; way/set/tag only reload on a response and otherwise hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            update_q     <= 1'b0;
            invalidate_q <= 1'b0;
            wake_q       <= '0;
            upd_way_q    <= '0;
            upd_tag_q    <= '0;
            upd_set_q    <= '0;
        end else begin
            update_q     <= rsp_fill;
            invalidate_q <= rsp_inval;
            wake_q       <= wake_d;
            if (l2_if.l2_rsp_valid) begin
                upd_way_q <= l2_if.l2_rsp_way;
                upd_tag_q <= l2_if.l2_rsp_addr[ADDR_W-1:L1_SET_INDEX_WIDTH];
                upd_set_q <= l2_if.l2_rsp_addr[L1_SET_INDEX_WIDTH-1:0];
            end
        end
    end

    // A new line with every entry busy has nowhere to go; the miss is dropped
    assert_false: assert property (@(posedge clk) disable iff (!reset) !(miss_i && !miss_hit && full_now));

    assign full_o             = full_q;
    assign l2_if.l2_req_valid = req_valid_q;
    assign l2_if.l2_req_addr  = req_addr_q;
    assign l2_if.l2_req_way   = req_way_q;
    assign update_o           = update_q;
    assign invalidate_o       = invalidate_q;
    assign update_way_o       = upd_way_q;
    assign update_tag_o       = upd_tag_q;
    assign update_set_o       = upd_set_q;
    assign wake_o             = wake_q;

endmodule

// File: tb/tb_l1_fill_ctrl.sv
// tb/tb_l1_fill_ctrl.sv - directed self-checking bench for l1_fill_ctrl
module tb_l1_fill_ctrl;

    logic        clk;
    logic        reset;
    logic        miss_i;
    logic [25:0] miss_addr_i;
    logic [1:0]  miss_strand_i;
    logic        full_o;
    logic        update_o;
    logic        invalidate_o;
    logic [1:0]  update_way_o;
    logic [18:0] update_tag_o;
    logic [6:0]  update_set_o;
    logic [3:0]  wake_o;

    int n_checks = 0;
    int n_errors = 0;

    l1_fill_ctrl_if l2_bus ();

    l1_fill_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .miss_i        (miss_i),
        .miss_addr_i   (miss_addr_i),
        .miss_strand_i (miss_strand_i),
        .full_o        (full_o),
        .l2_if         (l2_bus),
        .update_o      (update_o),
        .invalidate_o  (invalidate_o),
        .update_way_o  (update_way_o),
        .update_tag_o  (update_tag_o),
        .update_set_o  (update_set_o),
        .wake_o        (wake_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_miss(input logic [25:0] a, input logic [1:0] s);
        miss_i        = 1'b1;
        miss_addr_i   = a;
        miss_strand_i = s;
    endtask

    task automatic do_rsp(input logic t, input logic [25:0] a, input logic [1:0] w);
        l2_bus.l2_rsp_valid = 1'b1;
        l2_bus.l2_rsp_type  = t;
        l2_bus.l2_rsp_addr  = a;
        l2_bus.l2_rsp_way   = w;
    endtask

    task automatic idle_inputs();
        miss_i              = 1'b0;
        l2_bus.l2_rsp_valid = 1'b0;
        l2_bus.l2_req_ack   = 1'b0;
    endtask

    logic [25:0] line_tab [4];

    initial begin
        line_tab[0] = 26'h0000100;
        line_tab[1] = 26'h0000200;
        line_tab[2] = 26'h0000300;
        line_tab[3] = 26'h0000400;

        reset               = 1'b0;
        miss_i              = 1'b0;
        miss_addr_i         = '0;
        miss_strand_i       = '0;
        l2_bus.l2_req_ack   = 1'b0;
        l2_bus.l2_rsp_valid = 1'b0;
        l2_bus.l2_rsp_type  = 1'b0;
        l2_bus.l2_rsp_addr  = '0;
        l2_bus.l2_rsp_way   = '0;
        tick();
        tick();
        check("rst_req_valid", l2_bus.l2_req_valid, 0);
        check("rst_full", full_o, 0);
        check("rst_update", update_o, 0);
        check("rst_inval", invalidate_o, 0);
        check("rst_wake", wake_o, 0);
        check("rst_tag", update_tag_o, 0);
        reset = 1'b1;
        tick();

        // single miss, request, ack
        do_miss(26'h0001234, 2'd1);
        tick();
        idle_inputs();
        check("t1_req_not_yet", l2_bus.l2_req_valid, 0);
        tick();
        check("t1_req_valid", l2_bus.l2_req_valid, 1);
        check("t1_req_addr", l2_bus.l2_req_addr, 26'h0001234);
        check("t1_req_way", l2_bus.l2_req_way, 0);
        l2_bus.l2_req_ack = 1'b1;
        tick();
        idle_inputs();
        check("t1_req_dropped", l2_bus.l2_req_valid, 0);
        tick();
        check("t1_req_quiet", l2_bus.l2_req_valid, 0);

        // fill for that line
        do_rsp(1'b0, 26'h0001234, 2'd0);
        tick();
        idle_inputs();
        check("t2_update", update_o, 1);
        check("t2_inval", invalidate_o, 0);
        check("t2_way", update_way_o, 0);
        check("t2_set", update_set_o, 7'h34);
        check("t2_tag", update_tag_o, 19'h24);
        check("t2_wake", wake_o, 4'b0010);
        tick();
        check("t2_update_pulse", update_o, 0);
        check("t2_wake_pulse", wake_o, 0);
        check("t2_set_hold", update_set_o, 7'h34);

        // two strands on one line
        do_miss(26'h0000ABC, 2'd0);
        tick();
        do_miss(26'h0000ABC, 2'd2);
        tick();
        idle_inputs();
        check("t3_req_valid", l2_bus.l2_req_valid, 1);
        check("t3_req_addr", l2_bus.l2_req_addr, 26'h0000ABC);
        check("t3_req_way", l2_bus.l2_req_way, 1);
        l2_bus.l2_req_ack = 1'b1;
        tick();
        idle_inputs();
        tick();
        check("t3_single_req", l2_bus.l2_req_valid, 0);
        do_rsp(1'b0, 26'h0000ABC, 2'd1);
        tick();
        idle_inputs();
        check("t3_wake", wake_o, 4'b0101);
        check("t3_set", update_set_o, 7'h3C);
        check("t3_tag", update_tag_o, 19'h15);
        check("t3_way", update_way_o, 1);

        // fresh reset, then fill every entry
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            do_miss(line_tab[k], 2'(k));
            tick();
        end
        idle_inputs();
        check("t4_full", full_o, 1);
        for (int c = 0; c < 5; c++) begin
            check("t4_hold_valid", l2_bus.l2_req_valid, 1);
            check("t4_hold_addr", l2_bus.l2_req_addr, line_tab[0]);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            check("t4_grant_valid", l2_bus.l2_req_valid, 1);
            check("t4_grant_addr", l2_bus.l2_req_addr, line_tab[k]);
            check("t4_grant_way", l2_bus.l2_req_way, 32'(k));
            l2_bus.l2_req_ack = 1'b1;
            tick();
            l2_bus.l2_req_ack = 1'b0;
            check("t4_gap", l2_bus.l2_req_valid, 0);
            tick();
        end
        check("t4_all_issued", l2_bus.l2_req_valid, 0);

        // invalidate leaves pending entries alone
        do_rsp(1'b1, 26'h0000385, 2'd3);
        tick();
        idle_inputs();
        check("t5_inval", invalidate_o, 1);
        check("t5_update", update_o, 0);
        check("t5_way", update_way_o, 3);
        check("t5_set", update_set_o, 5);
        check("t5_tag", update_tag_o, 7);
        check("t5_wake", wake_o, 0);
        check("t5_still_full", full_o, 1);
        do_rsp(1'b0, line_tab[2], 2'd2);
        tick();
        idle_inputs();
        check("t5_fill_wake", wake_o, 4'b0100);
        check("t5_not_full", full_o, 0);

        // miss and fill for the same line together
        do_miss(line_tab[0], 2'd3);
        do_rsp(1'b0, line_tab[0], 2'd0);
        tick();
        idle_inputs();
        check("t6_update", update_o, 1);
        check("t6_wake", wake_o, 4'b1001);
        tick();
        check("t6_no_req", l2_bus.l2_req_valid, 0);
        tick();
        check("t6_no_req2", l2_bus.l2_req_valid, 0);

        // reset while a request is outstanding
        do_miss(26'h0000600, 2'd1);
        tick();
        idle_inputs();
        tick();
        check("t6_req_valid", l2_bus.l2_req_valid, 1);
        check("t6_req_addr", l2_bus.l2_req_addr, 26'h0000600);
        check("t6_req_way", l2_bus.l2_req_way, 0);
        reset = 1'b0;
        #1;
        check("t6_rst_req", l2_bus.l2_req_valid, 0);
        check("t6_rst_tag", update_tag_o, 0);
        check("t6_rst_wake", wake_o, 0);
        tick();
        reset = 1'b1;
        tick();
        do_rsp(1'b0, line_tab[1], 2'd1);
        tick();
        idle_inputs();
        check("t6_orphan_update", update_o, 1);
        check("t6_orphan_wake", wake_o, 0);
        check("t6_orphan_req", l2_bus.l2_req_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
